// File: rtl/hpdcache_dir_access_ctrl.sv
// HPDcache directory access controller: post-reset invalidation sweep,
// request arbitration onto the directory SRAM and a 2-entry read buffer.
module hpdcache_dir_access_ctrl #(
    parameter int SETS    = 64,
    parameter int WAYS    = 4,
    parameter int ENTRY_W = 32,
    localparam int SET_W  = $clog2(SETS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [SET_W-1:0]        req_set_i,
    input  logic [WAYS-1:0]         req_way_i,
    input  logic [WAYS*ENTRY_W-1:0] req_wentry_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WAYS*ENTRY_W-1:0] rsp_rentry_o,
    output logic                    init_done_o,
    output logic [SET_W-1:0]        dir_addr_o,
    output logic [WAYS-1:0]         dir_cs_o,
    output logic [WAYS-1:0]         dir_we_o,
    output logic [WAYS*ENTRY_W-1:0] dir_wentry_o,
    input  logic [WAYS*ENTRY_W-1:0] dir_rentry_i
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state_q, state_d;
    logic [SET_W-1:0]        cnt_q;
    logic                    init_done_q;
    logic                    rd_pending_q;
    logic [1:0]              occ_q;
    logic                    wr_ptr_q, rd_ptr_q;
    logic [WAYS*ENTRY_W-1:0] buf_q [2];

    logic       push, pop, accepted, rd_acc, wr_acc;
    logic [2:0] credit;

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d == RUN);
            if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (state_q == INIT && cnt_q == SET_W'(SETS - 1)) state_d = RUN;
    end

    // Credits count buffered plus in-flight reads, so a push never hits a full buffer
    assign pop      = rsp_valid_o & rsp_ready_i;
    assign push     = rd_pending_q;
    assign credit   = {1'b0, occ_q} + {2'b00, rd_pending_q} - {2'b00, pop};
    assign accepted = req_valid_i & req_ready_o;
    assign rd_acc   = accepted & ~req_we_i;
    assign wr_acc   = accepted & req_we_i;

    assign req_ready_o  = ~rst_i & (state_q == RUN) & (credit < 3'd2);
    assign rsp_valid_o  = ~rst_i & (occ_q != 2'd0);
    assign rsp_rentry_o = buf_q[rd_ptr_q];
    assign init_done_o  = ~rst_i & init_done_q;

    // FSM: outputs (SRAM port)
    always_comb begin
        dir_cs_o     = '0;
        dir_we_o     = '0;
        dir_addr_o   = '0;
        dir_wentry_o = '0;
        if (!rst_i) begin
            unique case (state_q)
                INIT: begin
                    dir_cs_o   = '1;
                    dir_we_o   = '1;
                    dir_addr_o = cnt_q;
                end
                RUN: begin
                    if (wr_acc) begin
                        dir_cs_o     = req_way_i;
                        dir_we_o     = req_way_i;
                        dir_addr_o   = req_set_i;
                        dir_wentry_o = req_wentry_i;
                    end else if (rd_acc) begin
                        dir_cs_o   = '1;
                        dir_addr_o = req_set_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pending_q <= 1'b0;
            occ_q        <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
        end else begin
            rd_pending_q <= rd_acc;
            occ_q        <= occ_q + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) buf_q[wr_ptr_q] <= dir_rentry_i;
    end

endmodule

// File: tb/tb_hpdcache_dir_access_ctrl.sv
// Bench for hpdcache_dir_access_ctrl: vector table plus scoreboard of
// expected read data, with an SRAM model behind the directory port.
module tb_hpdcache_dir_access_ctrl;

    localparam int SETS = 64;
    localparam int WAYS = 4;
    localparam int EW   = 32;
    localparam int DW   = WAYS * EW;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [5:0]    req_set_i = '0;
    logic [3:0]    req_way_i = '0;
    logic [DW-1:0] req_wentry_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rentry_o;
    logic          init_done_o;
    logic [5:0]    dir_addr_o;
    logic [3:0]    dir_cs_o;
    logic [3:0]    dir_we_o;
    logic [DW-1:0] dir_wentry_o;
    logic [DW-1:0] dir_rentry_i;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mdl [SETS];
    logic [DW-1:0] sb [$];
    logic [EW-1:0] sram [WAYS][SETS];

    always #5 clk = ~clk;

    hpdcache_dir_access_ctrl #(.SETS(SETS), .WAYS(WAYS), .ENTRY_W(EW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_set_i(req_set_i),
        .req_way_i(req_way_i), .req_wentry_i(req_wentry_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rentry_o(rsp_rentry_o), .init_done_o(init_done_o),
        .dir_addr_o(dir_addr_o), .dir_cs_o(dir_cs_o),
        .dir_we_o(dir_we_o), .dir_wentry_o(dir_wentry_o),
        .dir_rentry_i(dir_rentry_i)
    );

    // Directory SRAM: synchronous write, 1-cycle read latency
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (dir_cs_o[w]) begin
                if (dir_we_o[w]) sram[w][dir_addr_o] <= dir_wentry_o[w*EW +: EW];
                else dir_rentry_i[w*EW +: EW] <= sram[w][dir_addr_o];
            end
        end
    end

    typedef struct {
        logic          v;
        logic          we;
        logic [5:0]    set;
        logic [3:0]    way;
        logic [DW-1:0] wd;
        logic          rr;
        int            exp_rdy;
        int            exp_rv;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [5:0] set,
                         input logic [3:0] way, input logic [DW-1:0] wd,
                         input logic rr);
        @(negedge clk);
        req_valid_i  = v;
        req_we_i     = we;
        req_set_i    = set;
        req_way_i    = way;
        req_wentry_i = wd;
        rsp_ready_i  = rr;
        #1;
    endtask

    task automatic observe();
        if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got %h expected none", rsp_rentry_o);
            end else begin
                chk("rsp_data", rsp_rentry_o, sb[0]);
                if (rsp_ready_i) void'(sb.pop_front());
            end
        end
        if (req_valid_i && req_ready_o) begin
            if (req_we_i) begin
                chk("wr_cs", DW'(dir_cs_o), DW'(req_way_i));
                chk("wr_we", DW'(dir_we_o), DW'(req_way_i));
                chk("wr_addr", DW'(dir_addr_o), DW'(req_set_i));
                chk("wr_data", dir_wentry_o, req_wentry_i);
                for (int w = 0; w < WAYS; w++)
                    if (req_way_i[w]) mdl[req_set_i][w*EW +: EW] = req_wentry_i[w*EW +: EW];
            end else begin
                chk("rd_cs", DW'(dir_cs_o), DW'(4'hf));
                chk("rd_we", DW'(dir_we_o), '0);
                chk("rd_addr", DW'(dir_addr_o), DW'(req_set_i));
                sb.push_back(mdl[req_set_i]);
            end
        end
    endtask

    task automatic cyc(input logic v, input logic we, input logic [5:0] set,
                       input logic [3:0] way, input logic [DW-1:0] wd,
                       input logic rr);
        drive(v, we, set, way, wd, rr);
        observe();
    endtask

    task automatic sweep(input logic hold);
        logic ok;
        for (int i = 0; i < SETS; i++) begin
            @(negedge clk);
            rst_i        = 1'b0;
            req_valid_i  = hold;
            req_we_i     = 1'b1;
            req_set_i    = 6'd7;
            req_way_i    = 4'b0001;
            req_wentry_i = DW'(32'hDEAD_BEEF);
            rsp_ready_i  = 1'b1;
            #1;
            ok = dir_cs_o == 4'hf && dir_we_o == 4'hf && dir_addr_o == 6'(i)
                 && dir_wentry_o == '0 && !req_ready_o && !init_done_o && !rsp_valid_o;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL sweep[%0d]: cs=%h we=%h addr=%0d rdy=%b done=%b expected cs=f we=f addr=%0d rdy=0 done=0",
                         i, dir_cs_o, dir_we_o, dir_addr_o, req_ready_o, init_done_o, i);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(0, 0, 0, 0, '0, 1);
        chk("drain_empty", DW'(sb.size()), '0);
    endtask

    function automatic void add(input logic v, input logic we, input logic [5:0] set,
                                input logic [3:0] way, input logic [DW-1:0] wd,
                                input logic rr, input int er, input int ev);
        vec_t t;
        t.v = v; t.we = we; t.set = set; t.way = way; t.wd = wd;
        t.rr = rr; t.exp_rdy = er; t.exp_rv = ev;
        vt.push_back(t);
    endfunction

    initial begin
        for (int s = 0; s < SETS; s++) mdl[s] = '0;

        // back-to-back reads, free-flowing responses
        for (int i = 0; i < 4; i++) add(1, 0, 6'(i), 0, '0, 1, 1, (i >= 2) ? 1 : 0);
        add(0, 0, 0, 0, '0, 1, 1, 1);
        add(0, 0, 0, 0, '0, 1, 1, 1);
        add(0, 0, 0, 0, '0, 1, 1, 0);
        // fill sets 10..12 then stall responses
        add(1, 1, 10, 4'hf, {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000}, 1, 1, 0);
        add(1, 1, 11, 4'hf, {32'h1100_0003, 32'h1100_0002, 32'h1100_0001, 32'h1100_0000}, 1, 1, 0);
        add(1, 1, 12, 4'h5, {32'h1200_0003, 32'h1200_0002, 32'h1200_0001, 32'h1200_0000}, 1, 1, 0);
        add(1, 0, 10, 0, '0, 0, 1, 0);
        add(1, 0, 11, 0, '0, 0, 1, 0);
        add(1, 0, 12, 0, '0, 0, 0, 1);
        add(1, 0, 12, 0, '0, 0, 0, 1);
        add(1, 1, 13, 4'hf, {4{32'hBAD0_BAD0}}, 0, 0, 1);
        add(1, 0, 12, 0, '0, 1, 1, 1);
        add(1, 0, 13, 0, '0, 1, 1, 1);
        add(1, 1, 14, 4'h0, {4{32'hFFFF_FFFF}}, 1, 2, 2);
        add(1, 0, 14, 0, '0, 1, 2, 2);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", DW'(req_ready_o), '0);
        chk("rst_rv", DW'(rsp_valid_o), '0);
        chk("rst_done", DW'(init_done_o), '0);
        chk("rst_cs", DW'({dir_cs_o, dir_we_o}), '0);

        // sweep with a request held pending; accepted on first RUN cycle
        sweep(1'b1);
        cyc(1, 1, 7, 4'b0001, DW'(32'hDEAD_BEEF), 1);
        chk("run_done", DW'(init_done_o), DW'(1'b1));
        chk("run_ready", DW'(req_ready_o), DW'(1'b1));

        // write then read set 5, response two cycles after acceptance
        cyc(1, 1, 5, 4'b0010, DW'(32'hA5A5_0001) << 32, 0);
        cyc(1, 0, 5, 0, '0, 0);
        cyc(0, 0, 0, 0, '0, 0);
        chk("raw_rv_t1", DW'(rsp_valid_o), '0);
        cyc(0, 0, 0, 0, '0, 0);
        chk("raw_rv_t2", DW'(rsp_valid_o), DW'(1'b1));
        chk("raw_data", rsp_rentry_o, DW'(32'hA5A5_0001) << 32);
        drain();

        foreach (vt[i]) begin
            cyc(vt[i].v, vt[i].we, vt[i].set, vt[i].way, vt[i].wd, vt[i].rr);
            if (vt[i].exp_rdy != 2) chk($sformatf("vec%0d_ready", i), DW'(req_ready_o), DW'(vt[i].exp_rdy));
            if (vt[i].exp_rv != 2) chk($sformatf("vec%0d_rv", i), DW'(rsp_valid_o), DW'(vt[i].exp_rv));
        end
        drain();

        // reset with one buffered response and one read in flight
        cyc(1, 0, 10, 0, '0, 0);
        cyc(1, 0, 11, 0, '0, 0);
        @(negedge clk);
        rst_i = 1'b1;
        req_valid_i = 1'b1;
        req_we_i = 1'b0;
        #1;
        chk("mid_rst_rv", DW'(rsp_valid_o), '0);
        chk("mid_rst_ready", DW'(req_ready_o), '0);
        chk("mid_rst_cs", DW'(dir_cs_o), '0);
        chk("mid_rst_done", DW'(init_done_o), '0);
        sb.delete();
        for (int s = 0; s < SETS; s++) mdl[s] = '0;
        sweep(1'b0);
        cyc(0, 0, 0, 0, '0, 1);
        chk("rerun_done", DW'(init_done_o), DW'(1'b1));
        cyc(1, 0, 5, 0, '0, 1);
        cyc(1, 0, 7, 0, '0, 1);
        cyc(1, 0, 10, 0, '0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
